// File: rtl/pwr_event_sched_pkg.sv
// Shared constants for the switching-activity event scheduler.
package pwr_event_sched_pkg;

  // Scheduler state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default geometry
  localparam int unsigned DEF_N_SRC  = 4;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_PEND_W = 4;
  localparam int unsigned DEF_IDX_W  = 2;

endpackage

// File: rtl/pwr_event_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching cyclically from ptr+1.
module pwr_event_sched_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Walk the ring once starting after the last winner; keep the first hit
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/pwr_event_sched.sv
// Transition-event accounting: per-source pending counters feeding a shared
// counter bank through a round-robin single update port, with readout and drain.
module pwr_event_sched
  import pwr_event_sched_pkg::*;
#(
  parameter int unsigned N_SRC  = DEF_N_SRC,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned PEND_W = DEF_PEND_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic             C,
  input  logic             R_L,
  input  logic [N_SRC-1:0] ev,
  input  logic             clr,
  input  logic             flush,
  output logic             flush_done,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [N_SRC-1:0] gnt,
  output logic [N_SRC-1:0] ovf,
  output logic [N_SRC-1:0] sat,
  output logic             busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(N_SRC - 1);

  logic [PEND_W-1:0] pending [N_SRC];
  logic [CNT_W-1:0]  count   [N_SRC];
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [N_SRC-1:0]  req_c;
  logic [N_SRC-1:0]  ev_eff_c;
  logic              any_pend_c;
  logic [1:0]        state;
  logic [1:0]        state_nxt;

  // Request vector from registered pendings; events are masked while draining
  always_comb begin
    req_c = '0;
    for (int unsigned i = 0; i < N_SRC; i++) req_c[i] = |pending[i];
    any_pend_c = |req_c;
    ev_eff_c   = (state == ST_DRAIN) ? '0 : ev;
  end

  pwr_event_sched_rr_arbiter #(.N(N_SRC), .IW(IDX_W)) u_arb (
    .req     (req_c),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx_c)
  );

  assign busy = any_pend_c || (state != ST_IDLE);

  // Pending counters and overflow flags
  always_ff @(posedge C or negedge R_L) begin
    if (!R_L) begin
      for (int unsigned i = 0; i < N_SRC; i++) pending[i] <= '0;
      ovf <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < N_SRC; i++) pending[i] <= '0;
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (ev_eff_c[i] && !gnt[i]) begin
          if (pending[i] == PEND_MAX) ovf[i] <= 1'b1;
          else                        pending[i] <= pending[i] + PEND_W'(1);
        end else if (gnt[i] && !ev_eff_c[i]) begin
          pending[i] <= pending[i] - PEND_W'(1);
        end
      end
    end
  end

  // Shared counter bank, saturation flags and round-robin pointer
  always_ff @(posedge C or negedge R_L) begin
    if (!R_L) begin
      for (int unsigned i = 0; i < N_SRC; i++) count[i] <= '0;
      sat <= '0;
      ptr <= PTR_INIT;
    end else if (clr) begin
      for (int unsigned i = 0; i < N_SRC; i++) count[i] <= '0;
      sat <= '0;
      ptr <= PTR_INIT;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (gnt[i] && count[i] != CNT_MAX) begin
          count[i] <= count[i] + CNT_W'(1);
          if (count[i] == CNT_MAX - CNT_W'(1)) sat[i] <= 1'b1;
        end
      end
      if (|gnt) ptr <= gnt_idx_c;
    end
  end

  // Indexed readout; returns the pre-update value on a same-edge collision
  always_ff @(posedge C or negedge R_L) begin
    if (!R_L) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (32'(rd_idx) < N_SRC) rd_data <= count[rd_idx];
      else                     rd_data <= '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // State register; flush_done marks the single DONE cycle
  always_ff @(posedge C or negedge R_L) begin
    if (!R_L) begin
      state      <= ST_IDLE;
      flush_done <= 1'b0;
    end else if (clr) begin
      state      <= ST_IDLE;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush)           state_nxt = ST_DRAIN;
        else if (any_pend_c) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (flush)                         state_nxt = ST_DRAIN;
        else if (!any_pend_c && ev == '0)  state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!any_pend_c) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
